// File: rtl/syscall_ctrl.sv
// SYSCALL sequencing controller: print-to-LED with a PC hold window, halt until `go` is pressed.
// Optional SYSCALL_COUNT_EN builds a 16-bit serviced-syscall counter on sys_count.
module syscall_ctrl #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              syscall,
  input  logic [DATA_W-1:0] v0,
  input  logic [DATA_W-1:0] a0,
  output logic              pc_en,
  output logic [DATA_W-1:0] led_data,
  output logic              led_valid,
  output logic              halted,
  output logic [15:0]       sys_count
);

  localparam int unsigned CntW = (HOLD_CYCLES == 0) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [CntW-1:0] HoldLoad =
      (HOLD_CYCLES == 0) ? '0 : CntW'(HOLD_CYCLES - 1);
  localparam logic [DATA_W-1:0] SvcPrint = DATA_W'(34);
  localparam logic [DATA_W-1:0] SvcHalt  = DATA_W'(10);

  typedef enum logic [1:0] {
    StRun,
    StHold,
    StHalt
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [DATA_W-1:0] led_data_q, led_data_d;
  logic              led_valid_q, led_valid_d;
  logic              go_s1_q, go_s2_q, go_s3_q;
  logic              go_rise;

  // go_s1/go_s2 form the synchronizer; go_s3 only delays for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      go_s1_q <= 1'b0;
      go_s2_q <= 1'b0;
      go_s3_q <= 1'b0;
    end else begin
      go_s1_q <= go;
      go_s2_q <= go_s1_q;
      go_s3_q <= go_s2_q;
    end
  end

  assign go_rise = go_s2_q & ~go_s3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      hold_cnt_q  <= '0;
      led_data_q  <= '0;
      led_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      led_data_q  <= led_data_d;
      led_valid_q <= led_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    led_data_d  = led_data_q;
    led_valid_d = led_valid_q;
    unique case (state_q)
      StRun: begin
        if (syscall) begin
          if (v0 == SvcPrint) begin
            led_data_d  = a0;
            led_valid_d = 1'b1;
            if (HOLD_CYCLES > 0) begin
              hold_cnt_d = HoldLoad;
              state_d    = StHold;
            end
          end else if (v0 == SvcHalt) begin
            state_d = StHalt;
          end
        end
      end
      StHold: begin
        if (hold_cnt_q == '0) begin
          state_d = StRun;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      StHalt: begin
        if (go_rise) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  assign pc_en     = (state_q == StRun);
  assign halted    = (state_q == StHalt);
  assign led_data  = led_data_q;
  assign led_valid = led_valid_q;

`ifdef SYSCALL_COUNT_EN
  logic [15:0] sys_count_q;
  logic        svc_taken;

  assign svc_taken = (state_q == StRun) && syscall && ((v0 == SvcPrint) || (v0 == SvcHalt));

  always_ff @(posedge clk) begin
    if (rst) begin
      sys_count_q <= '0;
    end else if (svc_taken) begin
      sys_count_q <= sys_count_q + 16'd1;
    end
  end

  assign sys_count = sys_count_q;
`else
  assign sys_count = '0;
`endif

endmodule

// File: tb/tb_syscall_ctrl.sv
// Self-checking bench for syscall_ctrl: HOLD_CYCLES=4 and HOLD_CYCLES=0 instances share stimulus
// and are each compared against a cycle-level behavioural model.
module tb_syscall_ctrl;

  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          go = 1'b0;
  logic          syscall = 1'b0;
  logic [DW-1:0] v0 = '0;
  logic [DW-1:0] a0 = '0;

  logic          pc_en_a, led_valid_a, halted_a;
  logic [DW-1:0] led_data_a;
  logic [15:0]   sys_count_a;
  logic          pc_en_b, led_valid_b, halted_b;
  logic [DW-1:0] led_data_b;
  logic [15:0]   sys_count_b;

  syscall_ctrl #(.HOLD_CYCLES(4), .DATA_W(DW)) u_dut_h4 (
    .clk(clk), .rst(rst), .go(go), .syscall(syscall), .v0(v0), .a0(a0),
    .pc_en(pc_en_a), .led_data(led_data_a), .led_valid(led_valid_a),
    .halted(halted_a), .sys_count(sys_count_a)
  );

  syscall_ctrl #(.HOLD_CYCLES(0), .DATA_W(DW)) u_dut_h0 (
    .clk(clk), .rst(rst), .go(go), .syscall(syscall), .v0(v0), .a0(a0),
    .pc_en(pc_en_b), .led_data(led_data_b), .led_valid(led_valid_b),
    .halted(halted_b), .sys_count(sys_count_b)
  );

  // {pc_en, halted, led_valid, sys_count, led_data}
  logic [50:0] obs [2];
  assign obs[0] = {pc_en_a, halted_a, led_valid_a, sys_count_a, led_data_a};
  assign obs[1] = {pc_en_b, halted_b, led_valid_b, sys_count_b, led_data_b};

  // Behavioural model: stall_left counts remaining frozen cycles, halt is a flag.
  int unsigned hold_cyc [2] = '{4, 0};
  int unsigned stall_left [2];
  bit          m_halt [2];
  logic [31:0] m_led [2];
  bit          m_valid [2];
  int unsigned m_cnt [2];
  bit          go_hist [$] = '{0, 0, 0};  // go samples at edges t-3, t-2, t-1

  int checks = 0;
  int failures = 0;

  function automatic logic [50:0] expv(int d);
    logic [15:0] c;
`ifdef SYSCALL_COUNT_EN
    c = 16'(m_cnt[d]);
`else
    c = '0;
`endif
    return {(!m_halt[d] && stall_left[d] == 0), m_halt[d], m_valid[d], c, m_led[d]};
  endfunction

  task automatic model_edge();
    bit rise;
    rise = go_hist[1] && !go_hist[0];
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        stall_left[d] = 0;
        m_halt[d]     = 0;
        m_led[d]      = '0;
        m_valid[d]    = 0;
        m_cnt[d]      = 0;
      end else if (m_halt[d]) begin
        if (rise) m_halt[d] = 0;
      end else if (stall_left[d] > 0) begin
        stall_left[d]--;
      end else if (syscall) begin
        if (v0 == 34) begin
          m_led[d]      = a0;
          m_valid[d]    = 1;
          m_cnt[d]++;
          stall_left[d] = hold_cyc[d];
        end else if (v0 == 10) begin
          m_halt[d] = 1;
          m_cnt[d]++;
        end
      end
    end
    if (rst) begin
      go_hist = '{0, 0, 0};
    end else begin
      go_hist.push_back(go);
      void'(go_hist.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_sys(input logic [DW-1:0] v, input logic [DW-1:0] a);
    syscall = 1'b1;
    v0      = v;
    a0      = a;
    step();
    syscall = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== expv(d)) begin
        failures++;
        $display("FAIL reset dut%0d got=%h exp=%h", d, obs[d], expv(d));
      end
    end
    checks++;
    if ({pc_en_a, halted_a, led_valid_a, led_data_a} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      failures++;
      $display("FAIL reset_values got pc_en=%b halted=%b valid=%b led=%h", pc_en_a, halted_a,
               led_valid_a, led_data_a);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_print();
    int low;
    low = 0;
    do_sys(34, 5);
    for (int i = 0; i < 7; i++) begin
      if (!pc_en_a) low++;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== expv(d)) begin
          failures++;
          $display("FAIL print dut%0d cyc%0d got=%h exp=%h", d, i, obs[d], expv(d));
        end
      end
      step();
    end
    checks++;
    if (low != 4 || led_data_a !== 32'd5) begin
      failures++;
      $display("FAIL print_window got low_cycles=%0d led=%0d exp low_cycles=4 led=5", low,
               led_data_a);
    end
  endtask

  task automatic test_halt();
    int resume_at;
    resume_at = -1;
    do_sys(10, 0);
    do_sys(34, 7);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== expv(d)) begin
        failures++;
        $display("FAIL halt_ignore dut%0d got=%h exp=%h", d, obs[d], expv(d));
      end
    end
    checks++;
    if (halted_a !== 1'b1 || pc_en_a !== 1'b0 || led_data_a !== 32'd5) begin
      failures++;
      $display("FAIL halt_state got halted=%b pc_en=%b led=%0d exp 1 0 5", halted_a, pc_en_a,
               led_data_a);
    end
    step();
    go = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (resume_at < 0 && !halted_a) resume_at = i;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== expv(d)) begin
          failures++;
          $display("FAIL resume dut%0d cyc%0d got=%h exp=%h", d, i, obs[d], expv(d));
        end
      end
    end
    checks++;
    if (resume_at < 0 || resume_at > 3) begin
      failures++;
      $display("FAIL resume_latency got=%0d exp<=3", resume_at);
    end
    go = 1'b0;
    step();
    step();
  endtask

  task automatic test_go_held();
    go = 1'b1;
    repeat (4) step();
    do_sys(10, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== expv(d)) begin
          failures++;
          $display("FAIL go_held dut%0d cyc%0d got=%h exp=%h", d, i, obs[d], expv(d));
        end
      end
    end
    checks++;
    if (halted_a !== 1'b1) begin
      failures++;
      $display("FAIL go_held_stays got halted=%b exp 1", halted_a);
    end
    go = 1'b0;
    repeat (2) step();
    go = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== expv(d)) begin
          failures++;
          $display("FAIL go_retrig dut%0d cyc%0d got=%h exp=%h", d, i, obs[d], expv(d));
        end
      end
    end
    checks++;
    if (halted_a !== 1'b0 || pc_en_a !== 1'b1) begin
      failures++;
      $display("FAIL go_retrig_run got halted=%b pc_en=%b exp 0 1", halted_a, pc_en_a);
    end
    go = 1'b0;
    step();
  endtask

  task automatic test_ignored();
    do_sys(11, 9);
    do_sys(32'h0100_0022, 9);
    do_sys(32'h8000_000a, 9);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== expv(d)) begin
        failures++;
        $display("FAIL ignored dut%0d got=%h exp=%h", d, obs[d], expv(d));
      end
    end
    checks++;
    if (pc_en_a !== 1'b1 || halted_a !== 1'b0 || led_data_a === 32'd9) begin
      failures++;
      $display("FAIL ignored_state got pc_en=%b halted=%b led=%0d", pc_en_a, halted_a,
               led_data_a);
    end
  endtask

  task automatic test_reset_mid();
    do_sys(34, 3);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== expv(d)) begin
        failures++;
        $display("FAIL reset_hold dut%0d got=%h exp=%h", d, obs[d], expv(d));
      end
    end
    checks++;
    if ({pc_en_a, led_valid_a, sys_count_a, led_data_a} !== {1'b1, 1'b0, 16'd0, 32'd0}) begin
      failures++;
      $display("FAIL reset_hold_vals got pc_en=%b valid=%b cnt=%0d led=%0d", pc_en_a,
               led_valid_a, sys_count_a, led_data_a);
    end
    do_sys(10, 0);
    step();
    rst     = 1'b1;
    syscall = 1'b1;
    v0      = 34;
    a0      = 8;
    step();
    rst     = 1'b0;
    syscall = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== expv(d)) begin
        failures++;
        $display("FAIL reset_halt dut%0d got=%h exp=%h", d, obs[d], expv(d));
      end
    end
    checks++;
    if ({pc_en_a, halted_a, led_valid_a, led_data_a} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      failures++;
      $display("FAIL reset_halt_vals got pc_en=%b halted=%b valid=%b led=%0d", pc_en_a,
               halted_a, led_valid_a, led_data_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_cnt;
`ifdef SYSCALL_COUNT_EN
    exp_cnt = 16'd2;
`else
    exp_cnt = 16'd0;
`endif
    syscall = 1'b1;
    v0      = 34;
    a0      = 6;
    step();
    a0 = 7;
    step();
    syscall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== expv(d)) begin
          failures++;
          $display("FAIL b2b dut%0d cyc%0d got=%h exp=%h", d, i, obs[d], expv(d));
        end
      end
      checks++;
      if (pc_en_b !== 1'b1 || led_data_b !== 32'd7 || sys_count_b !== exp_cnt) begin
        failures++;
        $display("FAIL b2b_h0 cyc%0d got pc_en=%b led=%0d cnt=%0d exp 1 7 %0d", i, pc_en_b,
                 led_data_b, sys_count_b, exp_cnt);
      end
      step();
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 99) == 0);
      syscall = ($urandom_range(0, 3) == 0);
      r       = $urandom_range(0, 3);
      v0      = (r == 0) ? 32'd34 : (r == 1) ? 32'd10 : (r == 2) ? 32'd11 : $urandom;
      a0      = $urandom;
      if ($urandom_range(0, 7) == 0) go = ~go;
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== expv(d)) begin
          failures++;
          $display("FAIL random dut%0d cyc%0d got=%h exp=%h", d, i, obs[d], expv(d));
        end
      end
    end
    rst     = 1'b0;
    syscall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_print();
    test_halt();
    test_go_held();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/syscall_ctrl.md
# syscall_ctrl

Sequencing controller between the CPU's syscall decode and the board I/O. It services SYSCALL instructions: v0=34 latches a0 onto the LED display and freezes the PC for a fixed hold window; v0=10 halts the CPU until the `go` button is pressed. It owns the CPU's PC-enable so that display, halt and resume are handled by one state machine rather than spread across the datapath.

## Interface
Parameters:
- `HOLD_CYCLES`, 4: number of cycles `pc_en` stays low after a print syscall (0 = no stall).
- `DATA_W`, 32: width of `v0`, `a0`, `led_data`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `go`  in  1  resume button, asynchronous level; rising edge is detected internally.
- `syscall`  in  1  high for the cycle a SYSCALL instruction executes.
- `v0`  in  DATA_W  service number, sampled when `syscall`=1.
- `a0`  in  DATA_W  service argument, sampled when `syscall`=1.
- `pc_en`  out  1  1 = CPU may update PC at the next edge.
- `led_data`  out  DATA_W  last printed value.
- `led_valid`  out  1  sticky; set by the first print after reset.
- `halted`  out  1  1 while in HALT.
- `sys_count`  out  16  count of serviced syscalls (see Configuration).

## Operation
- States: RUN, HOLD, HALT. `pc_en` = (state==RUN); `halted` = (state==HALT). Both decode from registered state only, with no combinational path from inputs.
- A syscall is taken in RUN with `pc_en`=1, so the PC moves past the SYSCALL instruction. Stalls begin on the following cycle, and resume restarts at the next instruction.
- RUN, `syscall`=1, `v0`==34:
  - `led_data`<=`a0`; `led_valid`<=1.
  - If HOLD_CYCLES>0: load `hold_cnt`<=HOLD_CYCLES-1 and go to HOLD. Otherwise stay in RUN.
- RUN, `syscall`=1, `v0`==10: go to HALT. `led_data` is unchanged.
- RUN, `syscall`=1, any other `v0`: ignored. No state change, not counted.
- HOLD: if `hold_cnt`==0 go to RUN, else decrement. `syscall` and `go` are ignored.
- HALT: on `go_rise`, go to RUN. `syscall` is ignored (the PC is frozen).
- `go` path:
  - Two-flop synchronizer `go_s1`→`go_s2`, then `go_s3`<=`go_s2`.
  - `go_rise` = `go_s2` & ~`go_s3`.
  - `go_rise` in RUN or HOLD is discarded and is not remembered.
  - A held-high `go` produces exactly one `go_rise`.
- Width rules:
  - `v0` is compared against the full DATA_W value: 34 and 10 zero-extended.
  - `hold_cnt` is clog2(HOLD_CYCLES+1) bits, minimum 1.

## Timing
- Reset values:
  - state RUN.
  - `pc_en`=1, `halted`=0.
  - `led_data`=0, `led_valid`=0, `sys_count`=0.
  - `hold_cnt`=0.
  - `go_s1`/`go_s2`/`go_s3`=0.
- `rst` high at an edge overrides every other input in that cycle, including a simultaneous `syscall`. Reset taken mid-HOLD or mid-HALT returns to RUN immediately.
- Print: `syscall` seen at edge k, so `led_data` is valid after edge k. `pc_en`=0 for cycles k..k+HOLD_CYCLES-1 and returns to 1 after edge k+HOLD_CYCLES.
- Halt: `syscall` seen at edge k, so `halted`=1 and `pc_en`=0 from after edge k.
- Resume: `go` first sampled high at edge m gives `go_s2`=1 after m+1, `go_rise` in the following cycle, and RUN after edge m+2. Resume latency is 2–3 cycles from the asynchronous `go` rise.
- `go` already high when HALT is entered: no resume. A new low→high transition is required.

## Configuration
- `SYSCALL_COUNT_EN` defined:
  - `sys_count` increments by 1 at each edge where a syscall is serviced (v0==34 or v0==10 taken in RUN).
  - Wraps 0xFFFF→0x0000. Cleared by `rst`.
- Not defined: `sys_count` is constant 0 and no counter register is built. The port remains present.

## Test plan
- Reset, then `syscall`=1, v0=34, a0=5 for 1 cycle (HOLD_CYCLES=4) -> `led_data`=5, `led_valid`=1, `pc_en` low for exactly 4 cycles then 1; `sys_count`=1 (macro on).
- In RUN, `syscall`=1, v0=10 -> `halted`=1, `pc_en`=0. `syscall`=1, v0=34, a0=7 while halted -> `led_data` unchanged. `go` 0→1 -> RUN within 3 cycles, `halted`=0.
- `go` held high from before the halt -> CPU stays halted. `go` low then high -> resumes once. Holding `go` high causes no further effect.
- `syscall`=1, v0=11 -> no state change, `pc_en` stays 1, `sys_count` unchanged.
- `rst` asserted 2 cycles into HOLD, and separately during HALT -> next cycle state RUN, `pc_en`=1, `led_data`=0, `led_valid`=0, `sys_count`=0.
- HOLD_CYCLES=0, two back-to-back print syscalls a0=6, a0=7 -> `pc_en` never drops, `led_data`=7, `sys_count`=2. With macro off, `sys_count` stays 0 throughout.
